// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: producer request lanes and the registered CDB broadcast.
// master = producers/consumers side, slave = arbiter side.
interface cdb_arbiter_if #(
   parameter int N = 3
);
   logic [N-1:0]    req_valid;
   logic [4*N-1:0]  req_tag;
   logic [32*N-1:0] req_val;
   logic [32*N-1:0] req_addr;
   logic [N-1:0]    req_ready;
   logic            cdb_active;
   logic [3:0]      cdb_tag;
   logic [31:0]     cdb_val;
   logic [31:0]     cdb_addr;
   logic [1:0]      cdb_src;

   modport master (
      output req_valid, req_tag, req_val, req_addr,
      input  req_ready,
      input  cdb_active, cdb_tag, cdb_val, cdb_addr, cdb_src
   );

   modport slave (
      input  req_valid, req_tag, req_val, req_addr,
      output req_ready,
      output cdb_active, cdb_tag, cdb_val, cdb_addr, cdb_src
   );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-producer FIFOs, round-robin grant onto the registered CDB.
// Ports: clk_in, rst_in (sync, active-low), rdy_in (global stall), flush, bus (slave).
module cdb_arbiter #(
   parameter int         N        = 3,
   parameter int         DEPTH    = 2,
   parameter logic [3:0] TAG_NONE = 4'h0
) (
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic         rdy_in,
   input  logic         flush,
   cdb_arbiter_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // entry layout: {tag, val, addr}
   typedef logic [67:0] ent_t;

   ent_t          mem [N][DEPTH];
   logic [AW-1:0] hd  [N];
   logic [AW-1:0] tl  [N];
   logic [CW-1:0] cnt [N];
   logic [1:0]    rr_ptr;

   logic          go;
   logic [N-1:0]  ready;
   logic [N-1:0]  push;
   logic [N-1:0]  pop;
   ent_t          in_ent [N];
   logic          found;
   logic [1:0]    win;
   ent_t          head;

   logic          act_q;
   logic [3:0]    tag_q;
   logic [31:0]   val_q;
   logic [31:0]   addr_q;
   logic [1:0]    src_q;

   assign go = rdy_in && !flush;

   // ready uses the registered count only: a full FIFO never
   // gets credit for a pop happening on the same edge
   always_comb begin
      for (int i = 0; i < N; i++) begin
         in_ent[i] = {bus.req_tag[4*i +: 4],
                      bus.req_val[32*i +: 32],
                      bus.req_addr[32*i +: 32]};
         ready[i]  = go && (cnt[i] < CW'(DEPTH));
         push[i]   = bus.req_valid[i] && ready[i]
                     && (bus.req_tag[4*i +: 4] != TAG_NONE);
      end
   end

   // first non-empty FIFO at or after rr_ptr, wrapping modulo N
   always_comb begin
      logic [1:0] jj;
      found = 1'b0;
      win   = 2'd0;
      jj    = 2'd0;
      for (int k = 0; k < N; k++) begin
         jj = 2'((int'(rr_ptr) + k) % N);
         if (!found && cnt[jj] != '0) begin
            found = 1'b1;
            win   = jj;
         end
      end
      pop = '0;
      if (go && found)
         pop[win] = 1'b1;
      head = mem[win][hd[win]];
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         for (int i = 0; i < N; i++) begin
            hd[i]  <= '0;
            tl[i]  <= '0;
            cnt[i] <= '0;
         end
         rr_ptr <= 2'd0;
         act_q  <= 1'b0;
         tag_q  <= TAG_NONE;
         val_q  <= 32'd0;
         addr_q <= 32'd0;
         src_q  <= 2'd0;
      end else if (rdy_in) begin
         if (flush) begin
            for (int i = 0; i < N; i++) begin
               hd[i]  <= '0;
               tl[i]  <= '0;
               cnt[i] <= '0;
            end
            rr_ptr <= 2'd0;
            act_q  <= 1'b0;
            tag_q  <= TAG_NONE;
         end else begin
            for (int i = 0; i < N; i++) begin
               if (push[i]) begin
                  mem[i][tl[i]] <= in_ent[i];
                  tl[i]         <= tl[i] + 1'b1;
               end
               if (pop[i])
                  hd[i] <= hd[i] + 1'b1;
               cnt[i] <= cnt[i] + CW'(push[i]) - CW'(pop[i]);
            end
            if (found) begin
               {tag_q, val_q, addr_q} <= head;
               act_q  <= 1'b1;
               src_q  <= win;
               rr_ptr <= (win == 2'(N - 1)) ? 2'd0 : win + 2'd1;
            end else begin
               act_q <= 1'b0;
               tag_q <= TAG_NONE;
            end
         end
      end
   end

   assign bus.req_ready  = ready;
   assign bus.cdb_active = act_q;
   assign bus.cdb_tag    = tag_q;
   assign bus.cdb_val    = val_q;
   assign bus.cdb_addr   = addr_q;
   assign bus.cdb_src    = src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed checks of the CDB arbiter.
// Covers reset, single push, round-robin, backpressure, flush and stall.
module tb_cdb_arbiter;
   logic clk_in = 1'b0;
   logic rst_in;
   logic rdy_in;
   logic flush;
   int   errs   = 0;
   int   checks = 0;

   cdb_arbiter_if #(.N(3)) bus ();

   cdb_arbiter #(
      .N(3), .DEPTH(2), .TAG_NONE(4'h0)
   ) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .rdy_in (rdy_in),
      .flush  (flush),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [31:0] vv(input logic [3:0] t);
      return 32'h0000_1000 + 32'(t);
   endfunction

   function automatic logic [31:0] aa(input logic [3:0] t);
      return 32'h0000_2000 + 32'(t);
   endfunction

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic put(input int i, input logic [3:0] t);
      bus.req_valid[i]         = 1'b1;
      bus.req_tag[4*i +: 4]    = t;
      bus.req_val[32*i +: 32]  = vv(t);
      bus.req_addr[32*i +: 32] = aa(t);
   endtask

   task automatic drop(input int i);
      bus.req_valid[i] = 1'b0;
   endtask

   task automatic chk(input string name, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   task automatic bc(input string name, input logic [3:0] t,
                     input logic [1:0] s);
      chk({name, ".act"},  32'(bus.cdb_active), 32'd1);
      chk({name, ".tag"},  32'(bus.cdb_tag), 32'(t));
      chk({name, ".src"},  32'(bus.cdb_src), 32'(s));
      chk({name, ".val"},  bus.cdb_val, vv(t));
      chk({name, ".addr"}, bus.cdb_addr, aa(t));
   endtask

   task automatic idle(input string name);
      chk({name, ".act"}, 32'(bus.cdb_active), 32'd0);
      chk({name, ".tag"}, 32'(bus.cdb_tag), 32'd0);
   endtask

   initial begin
      rst_in        = 1'b0;
      rdy_in        = 1'b1;
      flush         = 1'b0;
      bus.req_valid = '0;
      bus.req_tag   = '0;
      bus.req_val   = '0;
      bus.req_addr  = '0;

      // reset held two edges with all producers valid
      put(0, 4'h1);
      put(1, 4'h2);
      put(2, 4'h3);
      tick();
      tick();
      rst_in        = 1'b1;
      bus.req_valid = '0;
      idle("rst");
      chk("rst.val",  bus.cdb_val, 32'd0);
      chk("rst.addr", bus.cdb_addr, 32'd0);
      chk("rst.src",  32'(bus.cdb_src), 32'd0);
      tick();
      idle("rst_nostore");

      // single push from requester 1
      put(1, 4'h5);
      bus.req_val[63:32]  = 32'hDEAD_BEEF;
      bus.req_addr[63:32] = 32'h0000_0100;
      tick();
      idle("single.nobypass");
      drop(1);
      tick();
      chk("single.act",  32'(bus.cdb_active), 32'd1);
      chk("single.tag",  32'(bus.cdb_tag), 32'h5);
      chk("single.val",  bus.cdb_val, 32'hDEAD_BEEF);
      chk("single.addr", bus.cdb_addr, 32'h0000_0100);
      chk("single.src",  32'(bus.cdb_src), 32'd1);
      tick();
      idle("single.pulse");
      chk("single.valhold", bus.cdb_val, 32'hDEAD_BEEF);
      chk("single.srchold", 32'(bus.cdb_src), 32'd1);

      // flush to bring rr_ptr back to 0
      flush = 1'b1;
      #1;
      chk("flush0.ready", 32'(bus.req_ready), 32'd0);
      tick();
      flush = 1'b0;
      idle("flush0.after");

      // round-robin: one entry in each FIFO
      put(0, 4'h1);
      put(1, 4'h2);
      put(2, 4'h3);
      #1;
      chk("rr.ready", 32'(bus.req_ready), 32'h7);
      tick();
      bus.req_valid = '0;
      idle("rr.lat");
      tick();
      bc("rr.g0", 4'h1, 2'd0);
      tick();
      bc("rr.g1", 4'h2, 2'd1);
      tick();
      bc("rr.g2", 4'h3, 2'd2);
      tick();
      idle("rr.empty");

      // backpressure on requester 0
      put(1, 4'hB);
      put(2, 4'hC);
      tick();
      drop(2);
      put(0, 4'h4);
      put(1, 4'hD);
      tick();
      bc("bp.b", 4'hB, 2'd1);
      drop(1);
      put(0, 4'h6);
      tick();
      bc("bp.c", 4'hC, 2'd2);
      put(0, 4'h7);
      #1;
      chk("bp.full", 32'(bus.req_ready), 32'h6);
      tick();
      bc("bp.4", 4'h4, 2'd0);
      chk("bp.stall1", 32'(bus.req_ready), 32'h7);
      tick();
      bc("bp.d", 4'hD, 2'd1);
      drop(0);
      tick();
      bc("bp.6", 4'h6, 2'd0);
      tick();
      bc("bp.7", 4'h7, 2'd0);
      tick();
      idle("bp.empty");

      // flush while tag 8 is broadcast, tag 9 queued behind it
      put(2, 4'h8);
      tick();
      idle("fl.lat");
      put(2, 4'h9);
      tick();
      bc("fl.8", 4'h8, 2'd2);
      drop(2);
      flush = 1'b1;
      put(0, 4'hE);
      #1;
      chk("fl.ready", 32'(bus.req_ready), 32'd0);
      bc("fl.8held", 4'h8, 2'd2);
      tick();
      flush = 1'b0;
      drop(0);
      idle("fl.after");
      tick();
      idle("fl.no9");
      tick();
      idle("fl.noE");

      // rdy_in stall with tag A on the CDB
      put(0, 4'hA);
      put(1, 4'h3);
      put(2, 4'h5);
      tick();
      idle("st.lat");
      bus.req_valid = '0;
      tick();
      bc("st.a", 4'hA, 2'd0);
      rdy_in = 1'b0;
      put(0, 4'hF);
      #1;
      chk("st.ready", 32'(bus.req_ready), 32'd0);
      for (int n = 0; n < 3; n++) begin
         tick();
         bc("st.hold", 4'hA, 2'd0);
      end
      rdy_in = 1'b1;
      put(0, 4'h0);
      #1;
      chk("st.none_ready", 32'(bus.req_ready), 32'h7);
      tick();
      bc("st.3", 4'h3, 2'd1);
      drop(0);
      tick();
      bc("st.5", 4'h5, 2'd2);
      tick();
      idle("st.none");
      tick();
      idle("st.end");

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
